// File: rtl/tom_spawn_scheduler.sv
// Enemy-cat spawn scheduler: frame-tick driven spawn/retire of NUM_TOMS slots
// plus Jerry's lives / invincibility state machine.

module tom_slot #(
    parameter int LIFETIME = 600
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       clr,
    input  logic       adv,
    input  logic       load,
    input  logic [9:0] lfsr,
    output logic       spawned,
    output logic [9:0] x_start,
    output logic [9:0] y_start,
    output logic [9:0] x_step,
    output logic [9:0] y_step
);
    localparam int LW = $clog2(LIFETIME);

    logic [LW-1:0] age;
    logic [9:0]    mag;

    assign mag = 10'd1 + {8'd0, lfsr[1:0]};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            spawned <= 1'b0;
            age     <= '0;
            x_start <= '0;
            y_start <= '0;
            x_step  <= '0;
            y_step  <= '0;
        end else if (clr) begin
            spawned <= 1'b0;
            age     <= '0;
        end else if (load) begin
            spawned <= 1'b1;
            age     <= '0;
            x_start <= 10'd64 + {1'b0, lfsr[8:0]};
            y_start <= 10'd16;
            x_step  <= lfsr[9] ? (~mag + 10'd1) : mag;
            y_step  <= 10'd1 + {8'd0, lfsr[3:2]};
        end else if (adv && spawned) begin
            // Retiring here keeps the slot busy for this tick's spawn attempt,
            // so the instance always sees at least one despawned frame.
            if (age == LW'(LIFETIME - 1)) begin
                spawned <= 1'b0;
                age     <= '0;
            end else begin
                age <= age + LW'(1);
            end
        end
    end
endmodule

module tom_spawn_scheduler #(
    parameter int         NUM_TOMS       = 4,
    parameter int         SPAWN_INTERVAL = 120,
    parameter int         LIFETIME       = 600,
    parameter int         INVINC_FRAMES  = 90,
    parameter int         START_LIVES    = 3,
    parameter logic [9:0] LFSR_SEED      = 10'h2A5
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  frame_clk,
    input  logic                  start,
    input  logic                  Pause,
    input  logic [NUM_TOMS-1:0]   KilledJerry,
    output logic [NUM_TOMS-1:0]   spawned,
    output logic [10*NUM_TOMS-1:0] X_Start,
    output logic [10*NUM_TOMS-1:0] Y_Start,
    output logic [10*NUM_TOMS-1:0] X_Step,
    output logic [10*NUM_TOMS-1:0] Y_Step,
    output logic                  Invincible,
    output logic [2:0]            lives,
    output logic                  game_over,
    output logic [1:0]            state
);
    localparam int TW = $clog2(SPAWN_INTERVAL);
    localparam int IW = $clog2(INVINC_FRAMES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HIT = 2'd2, OVER = 2'd3} st_t;

    st_t                 st;
    logic [2:0]          fsync;
    logic                tick;
    logic [9:0]          lfsr;
    logic [TW-1:0]       spawn_tmr;
    logic [IW-1:0]       inv_cnt;
    logic                active, ftick, adv, hit, to_over, restart, attempt, slot_clr, found;
    logic [NUM_TOMS-1:0] load_vec;

    assign state = st;

    // Two flops of synchronisation, a third for edge detect, then a registered pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fsync <= '0;
            tick  <= 1'b0;
            lfsr  <= LFSR_SEED;
        end else begin
            fsync <= {fsync[1:0], frame_clk};
            tick  <= fsync[1] & ~fsync[2];
            lfsr  <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    assign active   = (st == RUN) || (st == HIT);
    assign ftick    = tick & ~Pause;
    assign adv      = ftick & active;
    assign hit      = (st == RUN) & ~Pause & (|KilledJerry);
    assign to_over  = hit & (lives == 3'd1);
    assign restart  = start & ((st == IDLE) || (st == OVER));
    assign attempt  = adv & (spawn_tmr == TW'(SPAWN_INTERVAL - 1));
    assign slot_clr = (st == OVER) | to_over | restart;

    always_comb begin
        load_vec = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_TOMS; i++) begin
            if (attempt && !spawned[i] && !found) begin
                load_vec[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_TOMS; g++) begin : g_slot
        tom_slot #(.LIFETIME(LIFETIME)) u_slot (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .clr     (slot_clr),
            .adv     (adv),
            .load    (load_vec[g]),
            .lfsr    (lfsr),
            .spawned (spawned[g]),
            .x_start (X_Start[10*g +: 10]),
            .y_start (Y_Start[10*g +: 10]),
            .x_step  (X_Step[10*g +: 10]),
            .y_step  (Y_Step[10*g +: 10])
        );
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st         <= IDLE;
            lives      <= '0;
            spawn_tmr  <= '0;
            inv_cnt    <= '0;
            Invincible <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            case (st)
                IDLE, OVER: begin
                    if (start) begin
                        st         <= RUN;
                        lives      <= 3'(START_LIVES);
                        spawn_tmr  <= '0;
                        inv_cnt    <= '0;
                        Invincible <= 1'b0;
                        game_over  <= 1'b0;
                    end
                end
                default: begin
                    if (adv)
                        spawn_tmr <= attempt ? '0 : spawn_tmr + TW'(1);
                    if (hit) begin
                        lives <= lives - 3'd1;
                        if (lives == 3'd1) begin
                            st        <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            st         <= HIT;
                            Invincible <= 1'b1;
                            inv_cnt    <= '0;
                        end
                    end else if (st == HIT && ftick) begin
                        if (inv_cnt == IW'(INVINC_FRAMES - 1)) begin
                            st         <= RUN;
                            Invincible <= 1'b0;
                        end else begin
                            inv_cnt <= inv_cnt + IW'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tom_spawn_scheduler.sv
// Bench for tom_spawn_scheduler: frame-level game model plus a per-CLK LFSR model.

module tb_tom_spawn_scheduler;
    localparam int NT  = 4;
    localparam int SI  = 120;
    localparam int LT  = 600;
    localparam int INV = 90;
    localparam int SL  = 3;
    localparam int SEED = 'h2A5;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              frame_clk = 1'b0;
    logic              start = 1'b0;
    logic              Pause = 1'b0;
    logic [NT-1:0]     KilledJerry = '0;
    logic [NT-1:0]     spawned;
    logic [10*NT-1:0]  X_Start, Y_Start, X_Step, Y_Step;
    logic              Invincible;
    logic [2:0]        lives;
    logic              game_over;
    logic [1:0]        state;

    int n_cmp = 0;
    int n_err = 0;

    // Game model: 0 idle, 1 run, 2 hit, 3 over
    int m_st, m_lives, m_tmr, m_inv;
    int m_age[NT];
    bit m_sp[NT];
    int m_lfsr, m_lfsr_prev;
    logic [NT-1:0] sp_seen = '0;

    tom_spawn_scheduler #(
        .NUM_TOMS(NT), .SPAWN_INTERVAL(SI), .LIFETIME(LT), .INVINC_FRAMES(INV),
        .START_LIVES(SL), .LFSR_SEED(10'h2A5)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .frame_clk(frame_clk), .start(start),
        .Pause(Pause), .KilledJerry(KilledJerry), .spawned(spawned),
        .X_Start(X_Start), .Y_Start(Y_Start), .X_Step(X_Step), .Y_Step(Y_Step),
        .Invincible(Invincible), .lives(lives), .game_over(game_over), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_next(input int v);
        return ((v << 1) | (((v >> 9) ^ (v >> 6)) & 1)) & 1023;
    endfunction
    function automatic int exp_xs(input int v); return 64 + (v & 511); endfunction
    function automatic int exp_xst(input int v);
        int mag = 1 + (v & 3);
        return ((v >> 9) & 1) != 0 ? 1024 - mag : mag;
    endfunction
    function automatic int exp_yst(input int v); return 1 + ((v >> 2) & 3); endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_lfsr      <= SEED;
            m_lfsr_prev <= SEED;
        end else begin
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= lfsr_next(m_lfsr);
        end
    end

    // Every fresh spawn must carry values derived from the LFSR at the spawn edge.
    always @(negedge CLK) begin
        for (int i = 0; i < NT; i++) begin
            if (RESET_N && spawned[i] && !sp_seen[i]) begin
                chk("spawn_x_start", 64'(X_Start[10*i +: 10]), 64'(exp_xs(m_lfsr_prev)));
                chk("spawn_y_start", 64'(Y_Start[10*i +: 10]), 64'd16);
                chk("spawn_x_step",  64'(X_Step[10*i +: 10]),  64'(exp_xst(m_lfsr_prev)));
                chk("spawn_y_step",  64'(Y_Step[10*i +: 10]),  64'(exp_yst(m_lfsr_prev)));
            end
        end
        sp_seen <= spawned;
    end

    function automatic void m_clear_slots();
        for (int i = 0; i < NT; i++) begin
            m_sp[i]  = 1'b0;
            m_age[i] = 0;
        end
    endfunction

    function automatic void m_reset();
        m_st = 0; m_lives = 0; m_tmr = 0; m_inv = 0;
        m_clear_slots();
    endfunction

    function automatic logic [NT-1:0] m_spv();
        logic [NT-1:0] v = '0;
        for (int i = 0; i < NT; i++) v[i] = m_sp[i];
        return v;
    endfunction

    function automatic void m_frame(input bit paused);
        bit was_free[NT];
        int pick = -1;
        if (paused || !(m_st == 1 || m_st == 2)) return;
        for (int i = 0; i < NT; i++) was_free[i] = !m_sp[i];
        for (int i = 0; i < NT; i++) begin
            if (m_sp[i]) begin
                if (m_age[i] == LT - 1) begin
                    m_sp[i] = 1'b0;
                    m_age[i] = 0;
                end else m_age[i]++;
            end
        end
        if (m_tmr == SI - 1) begin
            m_tmr = 0;
            for (int i = 0; i < NT; i++) if (was_free[i] && pick < 0) pick = i;
            if (pick >= 0) begin
                m_sp[pick]  = 1'b1;
                m_age[pick] = 0;
            end
        end else m_tmr++;
        if (m_st == 2) begin
            if (m_inv == INV - 1) m_st = 1;
            else m_inv++;
        end
    endfunction

    function automatic void m_kill(input logic [NT-1:0] mask, input bit paused);
        if (paused || m_st != 1 || mask == '0) return;
        m_lives--;
        if (m_lives == 0) begin
            m_st = 3;
            m_clear_slots();
        end else begin
            m_st = 2;
            m_inv = 0;
        end
    endfunction

    function automatic void m_start();
        if (m_st == 0 || m_st == 3) begin
            m_st = 1; m_lives = SL; m_tmr = 0; m_inv = 0;
            m_clear_slots();
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_state"},   64'(state),      64'(m_st));
        chk({tag, "_lives"},   64'(lives),      64'(m_lives));
        chk({tag, "_spawned"}, 64'(spawned),    64'(m_spv()));
        chk({tag, "_invinc"},  64'(Invincible), 64'(m_st == 2));
        chk({tag, "_over"},    64'(game_over),  64'(m_st == 3));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},   64'(state),      64'd0);
        chk({tag, "_spawned"}, 64'(spawned),    64'd0);
        chk({tag, "_xstart"},  64'(X_Start),    64'd0);
        chk({tag, "_ystart"},  64'(Y_Start),    64'd0);
        chk({tag, "_xstep"},   64'(X_Step),     64'd0);
        chk({tag, "_ystep"},   64'(Y_Step),     64'd0);
        chk({tag, "_invinc"},  64'(Invincible), 64'd0);
        chk({tag, "_lives"},   64'(lives),      64'd0);
        chk({tag, "_over"},    64'(game_over),  64'd0);
    endtask

    task automatic frame();
        @(negedge CLK);
        frame_clk = 1'b1;
        repeat (4) @(negedge CLK);
        frame_clk = 1'b0;
        repeat (4) @(negedge CLK);
        m_frame(Pause);
        check_all("frame");
    endtask

    task automatic kill(input logic [NT-1:0] mask);
        @(negedge CLK);
        KilledJerry = mask;
        @(negedge CLK);
        KilledJerry = '0;
        m_kill(mask, Pause);
        check_all("kill");
    endtask

    task automatic do_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        m_start();
        check_all("start");
    endtask

    initial begin
        int r;
        m_reset();
        repeat (3) @(negedge CLK);
        chk_reset("reset");
        RESET_N = 1'b1;
        repeat (3) frame();

        // Fill, drop, retire-collision and refill with no kills
        do_start();
        repeat (120) frame();
        chk("t1_first_spawn", 64'(spawned), 64'd1);
        repeat (780) frame();

        // Multi-bit kill is one hit; kills during HIT are ignored
        kill(4'b0110);
        kill(4'b0001);
        kill(4'b0001);
        repeat (INV) frame();
        chk("t3_back_to_run", 64'(state), 64'd1);

        kill(4'b0001);
        repeat (INV) frame();
        kill(4'b1000);
        chk("t4_over_spawned", 64'(spawned), 64'd0);
        do_start();

        // Pause freezes everything, including kills
        repeat (130) frame();
        Pause = 1'b1;
        for (int k = 0; k < 200; k++) begin
            frame();
            if (k % 20 == 0) kill(4'b0101);
        end
        Pause = 1'b0;
        repeat (150) frame();

        repeat (400) begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
                Pause = ($urandom_range(0, 9) == 0);
                frame();
                Pause = 1'b0;
            end else if (r < 92) begin
                Pause = ($urandom_range(0, 5) == 0);
                kill(4'($urandom_range(0, 15)));
                Pause = 1'b0;
            end else begin
                do_start();
            end
        end

        // Asynchronous reset while in HIT, in the middle of a frame
        if (m_st == 0 || m_st == 3) do_start();
        if (m_st == 1) kill(4'b0001);
        if (m_st == 3) begin
            do_start();
            kill(4'b0001);
        end
        chk("t6_in_hit", 64'(state), 64'd2);
        @(negedge CLK);
        frame_clk = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset("t6_async");
        m_reset();
        frame_clk = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        do_start();
        repeat (121) frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
